exec_pipe_core: RTL and testbench

- Parametrised successor to the 8-bit pipelined datapath: a 4-stage in-order execution core (ID, EX, MEM, WB) with an internal register file and an internal data memory.
- Takes already-fetched, decoded instructions over a valid/ready handshake; the fetch/predict logic sits upstream.
- Resolves branches in EX and drives a redirect to fetch.
- Handles forwarding, load-use interlock, same-cycle RF bypass and a draining HALT internally.

---
 rtl/exec_pipe_pkg.sv | 71 +++++++
 rtl/exec_pipe_alu.sv | 33 +++
 rtl/exec_pipe_core.sv | 207 ++++++++++++++++++++
 tb/tb_exec_pipe_core.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pipe_pkg.sv
// Shared opcode encodings and decode helpers for the exec_pipe in-order core.
package exec_pipe_pkg;

  localparam int unsigned OpcodeW = 4;
  typedef logic [OpcodeW-1:0] opcode_t;

  localparam opcode_t OpNop   = 4'h0;
  localparam opcode_t OpAdd   = 4'h1;
  localparam opcode_t OpSub   = 4'h2;
  localparam opcode_t OpAnd   = 4'h3;
  localparam opcode_t OpOr    = 4'h4;
  localparam opcode_t OpXor   = 4'h5;
  localparam opcode_t OpSlt   = 4'h6;
  localparam opcode_t OpShl   = 4'h7;
  localparam opcode_t OpShr   = 4'h8;
  localparam opcode_t OpAddi  = 4'h9;
  localparam opcode_t OpLoad  = 4'ha;
  localparam opcode_t OpStore = 4'hb;
  localparam opcode_t OpBeq   = 4'hc;
  localparam opcode_t OpBne   = 4'hd;
  localparam opcode_t OpJmp   = 4'he;
  localparam opcode_t OpHalt  = 4'hf;

  typedef enum logic [2:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSlt, AluShl, AluShr
  } alu_op_e;

  function automatic logic is_load(input opcode_t op);
    return op == OpLoad;
  endfunction

  function automatic logic is_store(input opcode_t op);
    return op == OpStore;
  endfunction

  function automatic logic is_branch(input opcode_t op);
    return (op == OpBeq) || (op == OpBne) || (op == OpJmp);
  endfunction

  // ALU ops, ADDI and LOAD are the only register writers.
  function automatic logic writes_rd(input opcode_t op);
    return (op >= OpAdd) && (op <= OpLoad);
  endfunction

  function automatic logic uses_rs1(input opcode_t op);
    return (op >= OpAdd) && (op <= OpBne);
  endfunction

  // Shifts take their amount from imm, so they do not read rs2.
  function automatic logic uses_rs2(input opcode_t op);
    return ((op >= OpAdd) && (op <= OpSlt)) || is_store(op) || (op == OpBeq) || (op == OpBne);
  endfunction

  function automatic logic uses_imm(input opcode_t op);
    return (op == OpAddi) || is_load(op) || is_store(op);
  endfunction

  function automatic alu_op_e alu_sel(input opcode_t op);
    case (op)
      OpSub, OpBeq, OpBne: return AluSub;
      OpAnd:               return AluAnd;
      OpOr:                return AluOr;
      OpXor:               return AluXor;
      OpSlt:               return AluSlt;
      OpShl:               return AluShl;
      OpShr:               return AluShr;
      default:             return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/exec_pipe_alu.sv
// Combinational ALU with an equality flag used for branch resolution.
module exec_pipe_alu
  import exec_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  alu_op_e             op_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic [SHAMT_W-1:0]  shamt_i,
  output logic [DATA_W-1:0]   result_o,
  output logic                eq_o
);

  assign eq_o = (a_i == b_i);

  always_comb begin
    result_o = '0;
    unique case (op_i)
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i - b_i;
      AluAnd:  result_o = a_i & b_i;
      AluOr:   result_o = a_i | b_i;
      AluXor:  result_o = a_i ^ b_i;
      AluSlt:  result_o = {{(DATA_W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      AluShl:  result_o = a_i << shamt_i;
      AluShr:  result_o = a_i >> shamt_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/exec_pipe_core.sv
// Four-stage (ID/EX/MEM/WB) in-order core with internal RF, DMEM, forwarding and
// load-use interlock; branches resolve in EX and redirect upstream fetch.
module exec_pipe_core
  import exec_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RADDR_W  = 3,
  parameter int unsigned PC_W     = 8,
  parameter int unsigned DMEM_AW  = 4,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_opcode,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [RADDR_W-1:0] in_rs1,
  input  logic [RADDR_W-1:0] in_rs2,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic [PC_W-1:0]    in_pc,
  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc,
  output logic               retire_valid,
  output logic [RADDR_W-1:0] retire_rd,
  output logic [DATA_W-1:0]  retire_data,
  output logic               halted
);

  localparam int unsigned NumRegs   = 2**RADDR_W;
  localparam int unsigned DmemDepth = 2**DMEM_AW;
  localparam int unsigned ShW       = $clog2(DATA_W);

  logic [DATA_W-1:0] rf_q   [NumRegs];
  logic [DATA_W-1:0] dmem_q [DmemDepth];

  logic               ex_valid_q;
  opcode_t            ex_op_q;
  logic [RADDR_W-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic [DATA_W-1:0]  ex_a_q, ex_b_q, ex_imm_q;
  logic [PC_W-1:0]    ex_pc_q;

  logic               mem_valid_q;
  opcode_t            mem_op_q;
  logic [RADDR_W-1:0] mem_rd_q;
  logic [DATA_W-1:0]  mem_result_q, mem_sdata_q;

  logic               wb_valid_q;
  opcode_t            wb_op_q;
  logic [RADDR_W-1:0] wb_rd_q;
  logic [DATA_W-1:0]  wb_data_q;

  logic halt_seen_q, halted_q;

  function automatic logic is_zero_reg(input logic [RADDR_W-1:0] r);
    return ZERO_REG && (r == '0);
  endfunction

  // WB write, also the source for ID bypass and MEM/WB forwarding.
  logic rf_we;
  assign rf_we = wb_valid_q && writes_rd(wb_op_q) && !is_zero_reg(wb_rd_q);

  logic [DATA_W-1:0] id_a, id_b;
  always_comb begin
    id_a = rf_q[in_rs1];
    if (is_zero_reg(in_rs1))                id_a = '0;
    else if (rf_we && (wb_rd_q == in_rs1)) id_a = wb_data_q;
    id_b = rf_q[in_rs2];
    if (is_zero_reg(in_rs2))                id_b = '0;
    else if (rf_we && (wb_rd_q == in_rs2)) id_b = wb_data_q;
  end

  logic load_use, accept;
  assign load_use = ex_valid_q && is_load(ex_op_q) && !is_zero_reg(ex_rd_q) &&
                    ((uses_rs1(in_opcode) && (ex_rd_q == in_rs1)) ||
                     (uses_rs2(in_opcode) && (ex_rd_q == in_rs2)));
  assign in_ready = reset && !load_use && !redirect_valid && !halt_seen_q;
  assign accept   = in_valid && in_ready;

  // EX operand forwarding; a LOAD in MEM has no data yet and is covered by the interlock.
  logic fwd_mem_ok;
  logic [DATA_W-1:0] op_a, op_b, alu_b, alu_result;
  logic alu_eq;
  assign fwd_mem_ok = mem_valid_q && writes_rd(mem_op_q) && !is_load(mem_op_q) &&
                      !is_zero_reg(mem_rd_q);

  always_comb begin
    op_a = ex_a_q;
    if (fwd_mem_ok && (mem_rd_q == ex_rs1_q))  op_a = mem_result_q;
    else if (rf_we && (wb_rd_q == ex_rs1_q))   op_a = wb_data_q;
    op_b = ex_b_q;
    if (fwd_mem_ok && (mem_rd_q == ex_rs2_q))  op_b = mem_result_q;
    else if (rf_we && (wb_rd_q == ex_rs2_q))   op_b = wb_data_q;
  end

  assign alu_b = uses_imm(ex_op_q) ? ex_imm_q : op_b;

  alu_op_e alu_op;
  assign alu_op = alu_sel(ex_op_q);

  exec_pipe_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i     (alu_op),
    .a_i      (op_a),
    .b_i      (alu_b),
    .shamt_i  (ex_imm_q[ShW-1:0]),
    .result_o (alu_result),
    .eq_o     (alu_eq)
  );

  logic taken;
  logic [PC_W-1:0] br_target;
  always_comb begin
    taken = 1'b0;
    if (is_branch(ex_op_q)) begin
      case (ex_op_q)
        OpBeq:   taken = alu_eq;
        OpBne:   taken = !alu_eq;
        default: taken = 1'b1;
      endcase
    end
  end

  assign br_target      = ex_pc_q + PC_W'($signed(ex_imm_q));
  assign redirect_valid = ex_valid_q && taken;
  assign redirect_pc    = redirect_valid ? br_target : '0;

  logic [DMEM_AW-1:0] dmem_addr;
  logic [DATA_W-1:0]  wb_data_d;
  assign dmem_addr = mem_result_q[DMEM_AW-1:0];

  always_comb begin
    wb_data_d = '0;
    if (writes_rd(mem_op_q)) wb_data_d = is_load(mem_op_q) ? dmem_q[dmem_addr] : mem_result_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q   <= 1'b0;
      ex_op_q      <= OpNop;
      ex_rd_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_imm_q     <= '0;
      ex_pc_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_op_q     <= OpNop;
      mem_rd_q     <= '0;
      mem_result_q <= '0;
      mem_sdata_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_op_q      <= OpNop;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      halt_seen_q  <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      ex_valid_q <= accept;
      if (accept) begin
        ex_op_q  <= in_opcode;
        ex_rd_q  <= in_rd;
        ex_rs1_q <= in_rs1;
        ex_rs2_q <= in_rs2;
        ex_a_q   <= id_a;
        ex_b_q   <= id_b;
        ex_imm_q <= in_imm;
        ex_pc_q  <= in_pc;
      end
      mem_valid_q  <= ex_valid_q;
      mem_op_q     <= ex_op_q;
      mem_rd_q     <= ex_rd_q;
      mem_result_q <= alu_result;
      mem_sdata_q  <= op_b;
      wb_valid_q   <= mem_valid_q;
      wb_op_q      <= mem_op_q;
      wb_rd_q      <= writes_rd(mem_op_q) ? mem_rd_q : '0;
      wb_data_q    <= wb_data_d;
      if (accept && (in_opcode == OpHalt))        halt_seen_q <= 1'b1;
      if (mem_valid_q && (mem_op_q == OpHalt))    halted_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[wb_rd_q] <= wb_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DmemDepth; i++) dmem_q[i] <= '0;
    end else if (mem_valid_q && is_store(mem_op_q)) begin
      dmem_q[dmem_addr] <= mem_sdata_q;
    end
  end

  assign retire_valid = wb_valid_q;
  assign retire_rd    = wb_valid_q ? wb_rd_q : '0;
  assign retire_data  = wb_valid_q ? wb_data_q : '0;
  assign halted       = halted_q;

endmodule

// File: tb/tb_exec_pipe_core.sv
// Scoreboard bench for exec_pipe_core: default 8-bit instance plus a 16-bit reset check.
module tb_exec_pipe_core;
  import exec_pipe_pkg::*;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] data;
    bit         chk;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  logic       clk, reset;
  logic       in_valid, in_ready;
  logic [3:0] in_opcode;
  logic [2:0] in_rd, in_rs1, in_rs2;
  logic [7:0] in_imm, in_pc;
  logic       redirect_valid, retire_valid, halted;
  logic [7:0] redirect_pc, retire_data;
  logic [2:0] retire_rd;

  logic        v16, rdy16, rv16, ret16, halt16;
  logic [3:0]  op16, rd16, rs1_16, rs2_16, retrd16;
  logic [15:0] imm16, retdata16;
  logic [7:0]  pc16, rpc16;

  exec_pipe_core u_dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_opcode      (in_opcode),
    .in_rd          (in_rd),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_imm         (in_imm),
    .in_pc          (in_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .retire_valid   (retire_valid),
    .retire_rd      (retire_rd),
    .retire_data    (retire_data),
    .halted         (halted)
  );

  exec_pipe_core #(
    .DATA_W  (16),
    .RADDR_W (4)
  ) u_dut16 (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (v16),
    .in_ready       (rdy16),
    .in_opcode      (op16),
    .in_rd          (rd16),
    .in_rs1         (rs1_16),
    .in_rs2         (rs2_16),
    .in_imm         (imm16),
    .in_pc          (pc16),
    .redirect_valid (rv16),
    .redirect_pc    (rpc16),
    .retire_valid   (ret16),
    .retire_rd      (retrd16),
    .retire_data    (retdata16),
    .halted         (halt16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  // Monitor: every retirement pops one expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset === 1'b1 && retire_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL retire_unexpected: got rd=%0d data=0x%0h, want no retirement",
                 retire_rd, retire_data);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk) check("retire_rd_data", {retire_rd, retire_data}, {mon_e.rd, mon_e.data});
      end
    end
  end

  task automatic drive(input opcode_t op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm, input logic [7:0] pc);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_pc = pc;
  endtask

  task automatic issue(input opcode_t op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm, input logic [7:0] pc,
                       input bit chk, input logic [7:0] data, output int stalls);
    bit acc;
    exp_t e;
    acc = 1'b0;
    stalls = 0;
    while (!acc) begin
      @(negedge clk);
      drive(op, rd, rs1, rs2, imm, pc);
      #1;
      if (in_ready) begin
        acc = 1'b1;
        e.rd = rd; e.data = data; e.chk = chk;
        sb.push_back(e);
      end else if (stalls >= 16) begin
        total++;
        bad++;
        $display("FAIL issue_timeout: op=%0d got no accept in %0d cycles, want accept", op, stalls);
        acc = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wr(input opcode_t op, input logic [2:0] rd, input logic [2:0] rs1,
                    input logic [2:0] rs2, input logic [7:0] imm, input logic [7:0] data);
    int s;
    issue(op, rd, rs1, rs2, imm, 8'h00, 1'b1, data, s);
  endtask

  task automatic drive16(input opcode_t op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [15:0] imm);
    @(negedge clk);
    v16 = 1'b1; op16 = op; rd16 = rd; rs1_16 = rs1; rs2_16 = 4'd0; imm16 = imm; pc16 = 8'd0;
    #1 check("dut16_ready", rdy16, 1);
    @(posedge clk);
    #1 v16 = 1'b0;
  endtask

  int st;
  bit acc;
  logic rv;
  logic [7:0] rpc;

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_opcode = OpNop; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_pc = '0;
    v16 = 1'b0; op16 = OpNop; rd16 = '0; rs1_16 = '0; rs2_16 = '0; imm16 = '0; pc16 = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_redirect", {redirect_valid, redirect_pc}, 0);
    check("rst_retire", {retire_valid, retire_rd, retire_data}, 0);
    check("rst_halted", halted, 0);
    @(negedge clk) reset = 1'b1;
    #1 check("ready_after_reset", in_ready, 1);

    // Forwarding with no stalls
    wr(OpAddi, 3'd1, 3'd0, 3'd0, 8'd5, 8'd5);
    wr(OpAddi, 3'd2, 3'd0, 3'd0, 8'd7, 8'd7);
    issue(OpAdd, 3'd3, 3'd1, 3'd2, 8'd0, 8'd0, 1'b1, 8'd12, st);
    check("add_fwd_stalls", st, 0);

    // Store then load-use
    issue(OpStore, 3'd0, 3'd0, 3'd3, 8'd2, 8'd0, 1'b0, 8'd0, st);
    wr(OpLoad, 3'd4, 3'd0, 3'd0, 8'd2, 8'd12);
    issue(OpAdd, 3'd5, 3'd4, 3'd4, 8'd0, 8'd0, 1'b1, 8'd24, st);
    check("load_use_stalls", st, 1);

    // Taken branch: wrong-path instruction must be refused
    issue(OpBeq, 3'd0, 3'd1, 3'd1, 8'd4, 8'd10, 1'b0, 8'd0, st);
    @(negedge clk);
    drive(OpAddi, 3'd6, 3'd0, 3'd0, 8'h55, 8'd11);
    #1;
    acc = in_ready; rv = redirect_valid; rpc = redirect_pc;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("beq_redirect_valid", rv, 1);
    check("beq_redirect_pc", rpc, 8'd14);
    check("beq_wrong_path_refused", acc, 0);
    issue(OpAddi, 3'd6, 3'd0, 3'd0, 8'h11, 8'd14, 1'b1, 8'h11, st);
    check("after_redirect_stalls", st, 0);

    // Not-taken branch costs nothing
    issue(OpBne, 3'd0, 3'd1, 3'd1, 8'd4, 8'd20, 1'b0, 8'd0, st);
    issue(OpAddi, 3'd7, 3'd0, 3'd0, 8'h22, 8'd21, 1'b1, 8'h22, st);
    check("bne_not_taken_stalls", st, 0);

    // Wrap-around arithmetic and ALU ops
    wr(OpAddi, 3'd1, 3'd0, 3'd0, 8'hff, 8'hff);
    wr(OpAddi, 3'd1, 3'd1, 3'd0, 8'h01, 8'h00);
    wr(OpAddi, 3'd2, 3'd0, 3'd0, 8'h01, 8'h01);
    wr(OpSub,  3'd7, 3'd0, 3'd2, 8'h00, 8'hff);
    wr(OpAddi, 3'd3, 3'd0, 3'd0, 8'h80, 8'h80);
    wr(OpSlt,  3'd4, 3'd3, 3'd2, 8'h00, 8'h01);
    wr(OpXor,  3'd5, 3'd3, 3'd7, 8'h00, 8'h7f);
    wr(OpShr,  3'd6, 3'd3, 3'd0, 8'h03, 8'h10);
    wr(OpShl,  3'd6, 3'd7, 3'd0, 8'h04, 8'hf0);
    wr(OpAnd,  3'd5, 3'd7, 3'd3, 8'h00, 8'h80);
    wr(OpOr,   3'd5, 3'd2, 3'd3, 8'h00, 8'h81);

    // r0 stays zero even right after a write to it
    wr(OpAddi, 3'd0, 3'd0, 3'd0, 8'h09, 8'h09);
    wr(OpAdd,  3'd5, 3'd0, 3'd0, 8'h00, 8'h00);

    // Address wrap: 0x80+0x13 and 0xf3 both land on word 3
    issue(OpStore, 3'd0, 3'd3, 3'd2, 8'h13, 8'd0, 1'b0, 8'd0, st);
    wr(OpLoad, 3'd6, 3'd0, 3'd0, 8'hf3, 8'h01);

    // Reset with three instructions in flight
    wr(OpAddi, 3'd1, 3'd0, 3'd0, 8'h21, 8'h21);
    wr(OpAddi, 3'd2, 3'd0, 3'd0, 8'h22, 8'h22);
    wr(OpAddi, 3'd3, 3'd0, 3'd0, 8'h23, 8'h23);
    wr(OpAddi, 3'd4, 3'd0, 3'd0, 8'h24, 8'h24);
    @(negedge clk);
    #2 reset = 1'b0;
    sb.delete();
    #1 check("midrst_outputs",
             {in_ready, redirect_valid, redirect_pc, retire_valid, retire_rd, retire_data, halted}, 0);
    @(negedge clk) reset = 1'b1;
    #1 check("midrst_ready_after", in_ready, 1);
    wr(OpAdd, 3'd5, 3'd1, 3'd2, 8'h00, 8'h00);

    // HALT drains and locks the input
    wr(OpAddi, 3'd1, 3'd0, 3'd0, 8'h03, 8'h03);
    issue(OpHalt, 3'd0, 3'd0, 3'd0, 8'h00, 8'd0, 1'b0, 8'd0, st);
    @(negedge clk);
    drive(OpAddi, 3'd2, 3'd0, 3'd0, 8'h77, 8'd0);
    #1 check("halt_c1", {halted, in_ready}, 2'b00);
    @(negedge clk);
    #1 check("halt_c2", {halted, in_ready}, 2'b00);
    @(negedge clk);
    #1 check("halt_c3", {halted, in_ready}, 2'b10);
    repeat (4) @(negedge clk);
    #1 check("halt_sticky", {halted, in_ready}, 2'b10);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    // 16-bit instance: reset mid-stream must clear RF
    drive16(OpAddi, 4'd9, 4'd0, 16'h1234);
    drive16(OpAddi, 4'd10, 4'd9, 16'h0101);
    drive16(OpAddi, 4'd11, 4'd0, 16'h0001);
    @(negedge clk);
    v16 = 1'b1; op16 = OpAddi; rd16 = 4'd12; rs1_16 = 4'd0; imm16 = 16'h0002;
    #1 check("dut16_retire_r9", {ret16, retrd16, retdata16}, {1'b1, 4'd9, 16'h1234});
    @(posedge clk);
    #1 v16 = 1'b0;
    @(negedge clk);
    #1 check("dut16_retire_r10", {ret16, retrd16, retdata16}, {1'b1, 4'd10, 16'h1335});
    #1 reset = 1'b0;
    #1 check("dut16_midrst_outputs",
             {rdy16, rv16, rpc16, ret16, retrd16, retdata16, halt16}, 0);
    @(negedge clk) reset = 1'b1;
    v16 = 1'b1; op16 = OpAdd; rd16 = 4'd13; rs1_16 = 4'd9; rs2_16 = 4'd9; imm16 = 16'h0;
    #1 check("dut16_ready_after", rdy16, 1);
    @(posedge clk);
    #1 v16 = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("dut16_rf_cleared", {ret16, retrd16, retdata16}, {1'b1, 4'd13, 16'h0000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
